alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
//  Shares one 4-bit ALU (add/sub/and/or with zero/negative/carry flags) between NREQ requesters.
//  Round-robin arbitration, valid/ready request and response handshakes, registered result and flags.
//  Sits between the requesters and a single internal instance of the team's alu block.
// PARAMETERS
//  NREQ  2              number of requesters (2..8)
//  ID_W  $clog2(NREQ)   width of the rsp_id field
// PORTS
//  clk        in   1          single clock; all logic rising-edge
//  rst_n      in   1          asynchronous, active-low reset
//  req_valid  in   NREQ       per-requester request valid
//  req_ready  out  NREQ       per-requester accept; at most one bit high
//  req_a      in   4*NREQ     operand A, requester i at [4i+3:4i]
//  req_b      in   4*NREQ     operand B, same packing
//  req_sel    in   2*NREQ     opcode: 00 add, 01 sub, 10 and, 11 or
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_id     out  ID_W       index of the requester served
//  rsp_y      out  4          result y[3:0]
//  rsp_k      out  1          zero flag (y==0)
//  rsp_n      out  1          negative flag (y[3])
//  rsp_c      out  1          carry/borrow: bit 4 of the 5-bit result; always 0 for and/or
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready, rsp_valid, rsp_id, rsp_y, rsp_k, rsp_n, rsp_c all 0; last_grant=NREQ-1.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: req_ready = one-hot grant over req_valid (combinational). Grant search starts at last_grant+1
//    and wraps modulo NREQ. Handshake (valid&ready) in cycle T: capture a/b/sel/id, set last_grant=id,
//    go EXEC. No valid request: stay IDLE.
//   EXEC (T+1): the ALU evaluates the captured operands combinationally.
//    Register y/k/n/c/id into the rsp_* outputs; go RESP.
//   RESP: rsp_valid=1 from T+2. Hold all rsp_* stable until rsp_valid&rsp_ready, then go IDLE.
//    rsp_valid drops in the following cycle.
//  req_ready is 0 in EXEC and RESP. Minimum 3 cycles per operation; no overlap.
//  Requesters hold req_a/b/sel stable while valid and not granted. A deasserted valid is simply skipped.
//  Arithmetic is mod 16 for y. c is the 5-bit result's MSB: 9+8 -> c=1; 3-5 -> 5'b11110 -> c=1.
//  Only one requester valid: it is granted every IDLE cycle, with no fairness penalty.
//  All requesters valid: strict rotation 0,1,..,NREQ-1,0.
//  Reset mid-operation: in-flight op discarded with no response. Arbitration pointer restored to reset value.
//  rsp_ready high while rsp_valid low: ignored.
// CONFIGURATION
//  Macro ALU_STICKY_CARRY_EN.
//  Defined: adds ports sticky_clr in NREQ and sticky_c out NREQ (reset 0).
//   sticky_c[i] sets in the EXEC cycle when a requester-i op yields c=1.
//   sticky_clr[i] clears it on the next edge.
//   Set and clear in the same cycle: set wins.
//  Not defined: neither port exists; no sticky state; all other behaviour identical.
// STRUCTURE
//  Package alu_sched_pkg:
//   opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
//   FSM state encoding S_IDLE/S_EXEC/S_RESP.
//  Sub-module rr_arbiter #(NREQ): req vector + last_grant in -> one-hot grant + encoded index out; purely combinational.
//  The existing alu is instantiated once; its y/k/n/c outputs feed the response registers.
// TESTING
//  1. Req0 a=9 b=8 add, rsp_ready=1 -> at T+2: rsp_valid=1, id=0, y=1, k=0, n=0, c=1.
//  2. Req1 a=3 b=5 sub -> id=1, y=4'hE, n=1, c=1, k=0.
//     Then a=4'hA b=4'h5 and -> y=0, k=1, c=0.
//  3. Both requesters valid continuously for 6 ops -> rsp_id order 0,1,0,1,0,1; no req_ready overlap.
//  4. rsp_ready low for 5 cycles during RESP -> rsp_* held stable, req_ready=0 throughout.
//     One cycle after rsp_ready rises, FSM is in IDLE.
//  5. Assert rst_n low during EXEC -> rsp_valid=0 immediately, no response emitted.
//     After release, requester 0 wins a tie first.
//  6. With ALU_STICKY_CARRY_EN: req0 add 15+1 -> sticky_c[0]=1.
//     Then sticky_clr[0] plus another carry op in the same cycle -> stays 1; a lone clr -> 0.

Source files
------------

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes and FSM states.
// Optional feature macro used by the scheduler: ALU_STICKY_CARRY_EN.
package alu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bus between NREQ requesters, one response consumer and the scheduler.
// Handshake: a transfer happens in a cycle where valid and ready are both high.
// On the request side, a requester holds a/b/sel stable while valid is high and it is not granted.
// On the response side, rsp_* stay stable from rsp_valid rising until the cycle where rsp_ready is also high.
interface alu_rr_scheduler_if #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [3:0]        rsp_y;
    logic              rsp_k;
    logic              rsp_n;
    logic              rsp_c;

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_k, rsp_n, rsp_c
    );

    // Requester / consumer side
    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_k, rsp_n, rsp_c
    );
endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// The shared 4-bit ALU: add/sub/and/or with zero, negative and carry/borrow flags.
// Carry is bit 4 of the 5-bit result, so a subtraction that borrows reports c=1.
module alu
    import alu_sched_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] sel_i,
    output logic [3:0] y_o,
    output logic       k_o,
    output logic       n_o,
    output logic       c_o
);

    logic [4:0] res;

    // 5-bit result; logical ops never produce a carry
    always_comb begin
        res = '0;
        case (sel_i)
            OP_ADD:  res = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  res = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  res = {1'b0, a_i & b_i};
            default: res = {1'b0, a_i | b_i};
        endcase
    end

    assign y_o = res[3:0];
    assign k_o = (res[3:0] == 4'd0);
    assign n_o = res[3];
    assign c_o = res[4];

endmodule

// File: rtl/alu_rr_scheduler_arb.sv
// Purely combinational round-robin arbiter: the search starts one past the
// last granted index and wraps modulo NREQ; the first valid requester wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] grant_idx_o,
    output logic            grant_any_o
);

    // Walk offsets 1..NREQ from the last grant; first hit is the winner
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any_o && (i == (int'(last_grant_i) + k) % NREQ) && req_i[i]) begin
                    grant_any_o = 1'b1;
                    grant_o[i]  = 1'b1;
                    grant_idx_o = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NREQ requesters with round-robin arbitration.
// Each operation walks IDLE -> EXEC -> RESP -> IDLE, so at least 3 cycles per op and no overlap.
// Optional macro ALU_STICKY_CARRY_EN adds per-requester sticky carry bits (sticky_clr in, sticky_c out).
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_scheduler_if.slave   bus,
    output state_t              dbg_state_o
`ifdef ALU_STICKY_CARRY_EN
    ,
    input  logic [NREQ-1:0]     sticky_clr,
    output logic [NREQ-1:0]     sticky_c
`endif
);

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] id_q;
    logic [3:0]      a_q, b_q;
    logic [1:0]      sel_q;

    logic [ID_W-1:0] rsp_id_q;
    logic [3:0]      rsp_y_q;
    logic            rsp_k_q, rsp_n_q, rsp_c_q;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            accept;
    logic            load_rsp;

    logic [3:0]      a_mux, b_mux;
    logic [1:0]      sel_mux;

    logic [3:0]      alu_y;
    logic            alu_k, alu_n, alu_c;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_any_o  (grant_any)
    );

    // Select the granted requester's operands for capture
    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        sel_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_mux   = bus.req_a[4*i +: 4];
                b_mux   = bus.req_b[4*i +: 4];
                sel_mux = bus.req_sel[2*i +: 2];
            end
        end
    end

    alu u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .y_o   (alu_y),
        .k_o   (alu_k),
        .n_o   (alu_n),
        .c_o   (alu_c)
    );

    // Next-state and handshake outputs; ready only offered while idle
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        accept        = 1'b0;
        load_rsp      = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = grant;
                if (grant_any) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                load_rsp = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the accepted request and move the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
        end else if (accept) begin
            last_grant_q <= grant_idx;
            id_q         <= grant_idx;
            a_q          <= a_mux;
            b_q          <= b_mux;
            sel_q        <= sel_mux;
        end
    end

    // Response registers, loaded once in EXEC and held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q <= '0;
            rsp_y_q  <= '0;
            rsp_k_q  <= 1'b0;
            rsp_n_q  <= 1'b0;
            rsp_c_q  <= 1'b0;
        end else if (load_rsp) begin
            rsp_id_q <= id_q;
            rsp_y_q  <= alu_y;
            rsp_k_q  <= alu_k;
            rsp_n_q  <= alu_n;
            rsp_c_q  <= alu_c;
        end
    end

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_k     = rsp_k_q;
    assign bus.rsp_n     = rsp_n_q;
    assign bus.rsp_c     = rsp_c_q;
    assign dbg_state_o   = state_q;

`ifdef ALU_STICKY_CARRY_EN
    logic [NREQ-1:0] sticky_q, sticky_d, sticky_set;

    // A carry in EXEC sets the owner's bit; set beats a simultaneous clear
    always_comb begin
        sticky_set = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (load_rsp && alu_c && (id_q == ID_W'(i))) begin
                sticky_set[i] = 1'b1;
            end
        end
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    end

    // Sticky carry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_c = sticky_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed table, multi-cycle corner sequences,
// then random traffic against a transaction-level reference model.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NREQ(N)) bus ();
    state_t dbg_state;
`ifdef ALU_STICKY_CARRY_EN
    logic [N-1:0] sticky_clr;
    logic [N-1:0] sticky_c;
`endif

    alu_rr_scheduler #(.NREQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
`ifdef ALU_STICKY_CARRY_EN
        ,
        .sticky_clr  (sticky_clr),
        .sticky_c    (sticky_c)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] s);
        bus.req_valid[i]     = v;
        bus.req_a[4*i +: 4]  = a;
        bus.req_b[4*i +: 4]  = b;
        bus.req_sel[2*i +: 2] = s;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_STICKY_CARRY_EN
        sticky_clr = '0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_bits", {bus.rsp_id, bus.rsp_y, bus.rsp_k, bus.rsp_n, bus.rsp_c}, 0);
`ifdef ALU_STICKY_CARRY_EN
        chk("rst_sticky", sticky_c, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated operation; called at a negedge with the DUT idle
    task automatic run_op(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] s, input logic [3:0] ey, input logic ek,
                          input logic en, input logic ec, input bit clr_exec);
        set_req(id, 1'b1, a, b, s);
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_grant"}, bus.req_ready, 32'd1 << id);
        @(negedge clk);
        set_req(id, 1'b0, 4'd0, 4'd0, 2'd0);
        chk({tag, "_exec_state"}, dbg_state, S_EXEC);
        chk({tag, "_exec_vld"}, bus.rsp_valid, 0);
        chk({tag, "_exec_rdy"}, bus.req_ready, 0);
`ifdef ALU_STICKY_CARRY_EN
        if (clr_exec) sticky_clr[id] = 1'b1;
`endif
        @(negedge clk);
`ifdef ALU_STICKY_CARRY_EN
        sticky_clr = '0;
`endif
        chk({tag, "_vld"}, bus.rsp_valid, 1);
        chk({tag, "_id"}, bus.rsp_id, id);
        chk({tag, "_ykNc"}, {bus.rsp_y, bus.rsp_k, bus.rsp_n, bus.rsp_c}, {ey, ek, en, ec});
        @(negedge clk);
        chk({tag, "_done_vld"}, bus.rsp_valid, 0);
        chk({tag, "_done_state"}, dbg_state, S_IDLE);
    endtask

    // ---------------- reference model ----------------
    // Returns {c, n, k, y} from integer arithmetic on the operands.
    function automatic logic [6:0] ref_alu(input int a, input int b, input int s);
        int r;
        int y;
        logic c;
        case (s)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        y = r & 15;
        c = ((s == 0) && (r > 15)) || ((s == 1) && (r < 0));
        return {c, (y >= 8) ? 1'b1 : 1'b0, (y == 0) ? 1'b1 : 1'b0, 4'(y)};
    endfunction

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] y;
        logic       k;
        logic       n;
        logic       c;
    } vec_t;

    vec_t tbl[7];

    // scoreboard: pending responses, packed {id, c, n, k, y}
    logic [IW+6:0] exp_q[$];

    initial begin
        int got;
        int order[6];
        logic [3:0]  ra[N];
        logic [3:0]  rb[N];
        logic [1:0]  rs[N];
        logic        rv[N];
        int last;
        int wait_c;
        int granted;
        int ops;
        logic [N-1:0] exp_ready;
        int g;
        logic [IW+6:0] head;
        logic [IW+6:0] snap;

        tbl[0] = '{0, 4'd9,  4'd8, OP_ADD, 4'h1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1, 4'd3,  4'd5, OP_SUB, 4'hE, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1, 4'hA,  4'h5, OP_AND, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{0, 4'hF,  4'h0, OP_OR,  4'hF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{0, 4'd7,  4'd9, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1, 4'd0,  4'd0, OP_SUB, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{0, 4'd8,  4'd1, OP_SUB, 4'h7, 1'b0, 1'b0, 1'b0};

        do_reset();

        // ---- table-driven single operations ----
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sel,
                   tbl[i].y, tbl[i].k, tbl[i].n, tbl[i].c, 1'b0);
        end

        // ---- both requesters valid: strict alternation ----
        do_reset();
        order = '{0, 1, 0, 1, 0, 1};
        set_req(0, 1'b1, 4'd1, 4'd2, OP_ADD);
        set_req(1, 1'b1, 4'd2, 4'd2, OP_ADD);
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            #1;
            chk("rot_onehot", ($countones(bus.req_ready) <= 1) ? 1 : 0, 1);
            if (bus.rsp_valid) begin
                chk("rot_id", bus.rsp_id, order[got]);
                chk("rot_y", bus.rsp_y, order[got] + 3);
                got++;
            end
            @(negedge clk);
        end
        chk("rot_count", got, 6);

        // ---- response backpressure ----
        do_reset();
        set_req(1, 1'b1, 4'd6, 4'd7, OP_ADD);
        @(negedge clk);
        set_req(1, 1'b0, 4'd0, 4'd0, OP_ADD);
        set_req(0, 1'b1, 4'd1, 4'd1, OP_ADD);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", bus.rsp_valid, 1);
            chk("bp_rsp", {bus.rsp_id, bus.rsp_y, bus.rsp_k, bus.rsp_n, bus.rsp_c}, {1'b1, 4'hD, 1'b0, 1'b1, 1'b0});
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_state", dbg_state, S_RESP);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", dbg_state, S_IDLE);
        chk("bp_vld_drop", bus.rsp_valid, 0);
        chk("bp_next_grant", bus.req_ready, 2'b01);

        // ---- reset during EXEC ----
        do_reset();
        set_req(0, 1'b1, 4'd1, 4'd1, OP_ADD);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rx_exec", dbg_state, S_EXEC);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rx_vld", bus.rsp_valid, 0);
        chk("rx_state", dbg_state, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx_no_rsp", bus.rsp_valid, 0);
        end
        set_req(0, 1'b1, 4'd1, 4'd1, OP_ADD);
        set_req(1, 1'b1, 4'd1, 4'd1, OP_ADD);
        #1;
        chk("rx_tie", bus.req_ready, 2'b01);

`ifdef ALU_STICKY_CARRY_EN
        // ---- sticky carry ----
        do_reset();
        run_op("stk_set", 0, 4'd15, 4'd1, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("stk_set", sticky_c, 2'b01);
        run_op("stk_both", 0, 4'd8, 4'd8, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("stk_setwins", sticky_c, 2'b01);
        sticky_clr[0] = 1'b1;
        @(negedge clk);
        sticky_clr = '0;
        chk("stk_clr", sticky_c, 2'b00);
`endif

        // ---- random traffic vs. transaction model ----
        do_reset();
        exp_q.delete();
        last    = N - 1;
        wait_c  = 0;
        granted = -1;
        ops     = 0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rs[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (granted == i || !rv[i]) begin
                    if (granted == i || $urandom_range(0, 2) == 0) begin
                        rv[i] = (granted == i) ? 1'($urandom_range(0, 1)) : 1'b1;
                        ra[i] = 4'($urandom_range(0, 15));
                        rb[i] = 4'($urandom_range(0, 15));
                        rs[i] = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
                set_req(i, rv[i], ra[i], rb[i], rs[i]);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = '0;
            g = -1;
            if (exp_q.size() == 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && rv[(last + k) % N]) g = (last + k) % N;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("rnd_ready", bus.req_ready, exp_ready);
            chk("rnd_vld", bus.rsp_valid, (exp_q.size() != 0 && wait_c == 0) ? 1 : 0);
            if (exp_q.size() != 0 && wait_c == 0) begin
                head = exp_q[0];
                snap = {bus.rsp_id, bus.rsp_c, bus.rsp_n, bus.rsp_k, bus.rsp_y};
                chk("rnd_rsp", snap, head);
            end
            granted = -1;
            if (exp_q.size() == 0) begin
                if (g >= 0) begin
                    exp_q.push_back({IW'(g), ref_alu(int'(ra[g]), int'(rb[g]), int'(rs[g]))});
                    wait_c  = 1;
                    last    = g;
                    granted = g;
                end
            end else if (wait_c > 0) begin
                wait_c--;
            end else if (bus.rsp_ready) begin
                void'(exp_q.pop_front());
                ops++;
            end
            @(negedge clk);
        end
        chk("rnd_ops", (ops > 20) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
